// File: rtl/axil_ram_prot.sv
// axil_ram_prot: AXI4-Lite RAM with one-entry holding registers per request
// channel, round-robin write/read arbitration and an optional privileged-write check.
module axil_ram_prot #(
    parameter int unsigned           DATA_WIDTH      = 32,
    parameter int unsigned           ADDR_WIDTH      = 32,
    parameter int unsigned           STRB_WIDTH      = DATA_WIDTH / 8,
    parameter int unsigned           MEM_ADDR_WIDTH  = 12,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR       = '0,
    parameter int unsigned           PRIV_WRITE      = 0,
    parameter int unsigned           PIPELINE_OUTPUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]            s_axil_awprot,
    input  logic                  s_axil_awvalid,
    output logic                  s_axil_awready,
    input  logic [DATA_WIDTH-1:0] s_axil_wdata,
    input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
    input  logic                  s_axil_wvalid,
    output logic                  s_axil_wready,
    output logic [1:0]            s_axil_bresp,
    output logic                  s_axil_bvalid,
    input  logic                  s_axil_bready,
    input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]            s_axil_arprot,
    input  logic                  s_axil_arvalid,
    output logic                  s_axil_arready,
    output logic [DATA_WIDTH-1:0] s_axil_rdata,
    output logic [1:0]            s_axil_rresp,
    output logic                  s_axil_rvalid,
    input  logic                  s_axil_rready
);

    localparam int unsigned OFFS_W = $clog2(STRB_WIDTH);
    localparam int unsigned HI_LSB = MEM_ADDR_WIDTH + OFFS_W;
    localparam int unsigned DEPTH  = 1 << MEM_ADDR_WIDTH;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;

    typedef enum logic {ARB_WR, ARB_RD} arb_e;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return (a >> HI_LSB) == (BASE_ADDR >> HI_LSB);
    endfunction

    function automatic logic [MEM_ADDR_WIDTH-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        return MEM_ADDR_WIDTH'(a >> OFFS_W);
    endfunction

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    arb_e                  arb_q, arb_d;
    logic                  awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
    logic                  aw_full_q, aw_full_d, w_full_q, w_full_d, ar_full_q, ar_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d, ar_addr_q, ar_addr_d;
    logic                  aw_prot0_q, aw_prot0_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0] w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d, rvalid_q, rvalid_d, s1_valid_q, s1_valid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d, s1_resp_q, s1_resp_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d, s1_data_q, s1_data_d;

    logic                  b_free, r_out_free, r_free, s1_move;
    logic                  wr_elig, rd_elig, wr_go, rd_go, mem_we;
    logic                  wr_in_range, wr_permit, rd_in_range;
    logic [1:0]            wr_resp, rd_resp;
    logic [DATA_WIDTH-1:0] rd_word, rd_val;
    logic                  unused_arprot;

    assign unused_arprot = ^s_axil_arprot;

    // Slot availability, eligibility and round-robin grant
    assign b_free      = !bvalid_q || s_axil_bready;
    assign r_out_free  = !rvalid_q || s_axil_rready;
    assign s1_move     = s1_valid_q && r_out_free;
    assign r_free      = (PIPELINE_OUTPUT != 0) ? (!s1_valid_q || r_out_free) : r_out_free;
    assign wr_elig     = aw_full_q && w_full_q && b_free;
    assign rd_elig     = ar_full_q && r_free;
    assign wr_go       = wr_elig && (!rd_elig || arb_q == ARB_WR);
    assign rd_go       = rd_elig && (!wr_elig || arb_q == ARB_RD);

    // Response classification; out-of-range beats a privilege violation
    assign wr_in_range = in_range(aw_addr_q);
    assign wr_permit   = (PRIV_WRITE == 0) || aw_prot0_q;
    assign wr_resp     = !wr_in_range ? RESP_DECERR : (!wr_permit ? RESP_SLVERR : RESP_OKAY);
    assign mem_we      = wr_go && wr_in_range && wr_permit;
    assign rd_in_range = in_range(ar_addr_q);
    assign rd_word     = mem[word_idx(ar_addr_q)];
    assign rd_val      = rd_in_range ? rd_word : '0;
    assign rd_resp     = rd_in_range ? RESP_OKAY : RESP_DECERR;

    // Next-state for holds, readies, response slots and arbiter
    always_comb begin
        arb_d      = arb_q;
        aw_addr_d  = aw_addr_q;
        aw_prot0_d = aw_prot0_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        ar_addr_d  = ar_addr_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        rvalid_d   = rvalid_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_resp_d  = s1_resp_q;

        aw_full_d = (aw_full_q && !wr_go) || (s_axil_awvalid && awready_q);
        w_full_d  = (w_full_q && !wr_go) || (s_axil_wvalid && wready_q);
        ar_full_d = (ar_full_q && !rd_go) || (s_axil_arvalid && arready_q);
        awready_d = !aw_full_d;
        wready_d  = !w_full_d;
        arready_d = !ar_full_d;

        if (s_axil_awvalid && awready_q) begin
            aw_addr_d  = s_axil_awaddr;
            aw_prot0_d = s_axil_awprot[0];
        end
        if (s_axil_wvalid && wready_q) begin
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end
        if (s_axil_arvalid && arready_q) begin
            ar_addr_d = s_axil_araddr;
        end

        if (wr_elig && rd_elig) begin
            arb_d = wr_go ? ARB_RD : ARB_WR;
        end

        if (wr_go) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_resp;
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        if (PIPELINE_OUTPUT != 0) begin
            if (rd_go) begin
                s1_valid_d = 1'b1;
                s1_data_d  = rd_val;
                s1_resp_d  = rd_resp;
            end else if (s1_move) begin
                s1_valid_d = 1'b0;
            end
            if (s1_move) begin
                rvalid_d = 1'b1;
                rdata_d  = s1_data_q;
                rresp_d  = s1_resp_q;
            end else if (rvalid_q && s_axil_rready) begin
                rvalid_d = 1'b0;
            end
        end else begin
            if (rd_go) begin
                rvalid_d = 1'b1;
                rdata_d  = rd_val;
                rresp_d  = rd_resp;
            end else if (rvalid_q && s_axil_rready) begin
                rvalid_d = 1'b0;
            end
        end
    end

    // Control and datapath registers; reset drops every held transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            arb_q      <= ARB_WR;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            arready_q  <= 1'b0;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            ar_full_q  <= 1'b0;
            aw_addr_q  <= '0;
            aw_prot0_q <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            ar_addr_q  <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= 2'b00;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= 2'b00;
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_resp_q  <= 2'b00;
        end else begin
            arb_q      <= arb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            arready_q  <= arready_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            ar_full_q  <= ar_full_d;
            aw_addr_q  <= aw_addr_d;
            aw_prot0_q <= aw_prot0_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            ar_addr_q  <= ar_addr_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_resp_q  <= s1_resp_d;
        end
    end

    // Byte-masked memory write; storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < int'(STRB_WIDTH); b++) begin
                if (w_strb_q[b]) begin
                    mem[word_idx(aw_addr_q)][b*8 +: 8] <= w_data_q[b*8 +: 8];
                end
            end
        end
    end

    assign s_axil_awready = awready_q;
    assign s_axil_wready  = wready_q;
    assign s_axil_arready = arready_q;
    assign s_axil_bvalid  = bvalid_q;
    assign s_axil_bresp   = bresp_q;
    assign s_axil_rvalid  = rvalid_q;
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

endmodule

// File: doc/axil_ram_prot.md
AXIL_RAM_PROT -- requirements
Module: axil_ram_prot

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DATA_WIDTH, 32, data bus width in bits (8/16/32/64).
  ADDR_WIDTH, 32, AXI byte address width.
  STRB_WIDTH, DATA_WIDTH/8, byte-strobe width.
  MEM_ADDR_WIDTH, 12, log2 of memory depth in words.
  BASE_ADDR, 0, byte base address of the memory window, aligned to window size.
  PRIV_WRITE, 0, 1 = writes require awprot[0]=1.
  PIPELINE_OUTPUT, 0, 1 = extra register stage on the R channel.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  clock; all logic on the rising edge.
  rst_n  in  1  reset; asynchronous assert, active-low.
  s_axil_awaddr/awprot/awvalid  in  ADDR_WIDTH/3/1  write address channel; s_axil_awready out 1.
  s_axil_wdata/wstrb/wvalid  in  DATA_WIDTH/STRB_WIDTH/1  write data channel; s_axil_wready out 1.
  s_axil_bresp out 2, s_axil_bvalid out 1, s_axil_bready in 1  write response channel.
  s_axil_araddr/arprot/arvalid  in  ADDR_WIDTH/3/1  read address channel; s_axil_arready out 1.
  s_axil_rdata out DATA_WIDTH, s_axil_rresp out 2, s_axil_rvalid out 1, s_axil_rready in 1  read data channel.

Function
REQ-003 Word index SHALL be addr[MEM_ADDR_WIDTH+log2(STRB_WIDTH)-1 : log2(STRB_WIDTH)]; low byte-offset bits are ignored.
REQ-004 An address SHALL be in range iff addr[ADDR_WIDTH-1 : MEM_ADDR_WIDTH+log2(STRB_WIDTH)] equals the same bits of BASE_ADDR.
REQ-005 AW, W and AR SHALL each have a one-entry holding register; a channel's ready SHALL be registered and high iff its holding register is empty next cycle.
REQ-006 AW and W SHALL be accepted independently, in either order or the same cycle.
REQ-007 A write SHALL commit on the first edge where AW and W holds are both full, the B slot is empty or being drained (bvalid&bready), and the arbiter grants write; both holds clear and bvalid rises on that edge.
REQ-008 A committed write SHALL update only the bytes with wstrb=1 and return bresp: OKAY(00) if in range and permitted; DECERR(11), no memory change, if out of range; SLVERR(10), no memory change, if PRIV_WRITE=1 and awprot[0]=0. Out of range takes precedence.
REQ-009 A read SHALL commit on the first edge where the AR hold is full, the R slot is free, and the arbiter grants read; rdata = memory word with rresp OKAY if in range, else rdata=0 with rresp DECERR.
REQ-010 Read latency from the AR handshake edge to rvalid high SHALL be 1 cycle when PIPELINE_OUTPUT=0 and 2 cycles when PIPELINE_OUTPUT=1; write latency from the later of the AW/W handshakes to bvalid high SHALL be 1 cycle.
REQ-011 When write and read are both eligible on the same edge, the arbiter SHALL grant the channel not granted at the last contention (round-robin), starting with write after reset; the uncontended channel is granted immediately.
REQ-012 bvalid/bresp and rvalid/rdata/rresp SHALL stay stable while valid and not ready; no new commit may overwrite an undrained slot.
REQ-013 Sustained throughput SHALL be at least one transaction per channel per two cycles with ready held high.
REQ-014 A read committed after a write to the same word SHALL return the written data.
REQ-015 arprot SHALL be ignored; awprot SHALL be ignored when PRIV_WRITE=0.

Reset
REQ-016 While rst_n=0, awready, wready, arready, bvalid and rvalid SHALL be 0; bresp, rresp and rdata SHALL be 0; all holds empty; arbiter state = write-first.
REQ-017 Readies SHALL rise on the first clk edge after rst_n deasserts.
REQ-018 Memory contents SHALL NOT be reset; reset mid-transaction SHALL discard all held and pending transactions without a memory write.

Verification
REQ-019 Write 0xDEADBEEF to 0x10 with wstrb=0xF, then read 0x10 -> bresp=00, rdata=0xDEADBEEF, rresp=00, rvalid 1 cycle after AR handshake (PIPELINE_OUTPUT=0).
REQ-020 Write 0x12345678 to 0x10 with wstrb=0x3 over 0xDEADBEEF -> read returns 0xDEAD5678.
REQ-021 MEM_ADDR_WIDTH=12, BASE_ADDR=0: write then read at 0x0001_0000 -> bresp=11, rresp=11, rdata=0, word 0 unchanged.
REQ-022 PRIV_WRITE=1: write 0xA5A5A5A5 to 0x20 with awprot=000 -> bresp=10, memory unchanged; repeat with awprot=001 -> bresp=00, data written.
REQ-023 W presented 3 cycles before AW, bready held low 5 cycles -> bvalid and bresp stable for all 5 cycles; next write does not commit until B drains.
REQ-024 Write and read eligible on the same edge, repeated twice -> grants alternate write, read, write; assert rst_n=0 while holds are full -> all valids 0, no memory write.
